// File: rtl/multi_button_debouncer.sv
// N-channel push-button debouncer: 2-flop synchronisers, shared sample tick,
// per-channel stable-sample filter with press/release/hold pulses and toggle output.
module multi_button_debouncer #(
    parameter int NUM_BUTTONS    = 4,
    parameter int SAMPLE_DIV     = 10000,
    parameter int STABLE_SAMPLES = 8,
    parameter int HOLD_SAMPLES   = 5000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_BUTTONS-1:0] button,
    input  logic [NUM_BUTTONS-1:0] toggle_mode,
    output logic [NUM_BUTTONS-1:0] button_state,
    output logic [NUM_BUTTONS-1:0] debounced,
    output logic [NUM_BUTTONS-1:0] press_pulse,
    output logic [NUM_BUTTONS-1:0] release_pulse,
    output logic [NUM_BUTTONS-1:0] hold_pulse,
    output logic                   sample_tick
);

    localparam int DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int SW = (STABLE_SAMPLES > 0) ? $clog2(STABLE_SAMPLES + 1) : 1;
    localparam int HW = $clog2(HOLD_SAMPLES + 1);

    localparam logic [DW-1:0] DIV_LAST    = DW'(SAMPLE_DIV - 1);
    localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_SAMPLES - 1);
    localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_SAMPLES - 1);
    localparam logic [HW-1:0] HOLD_MAX    = HW'(HOLD_SAMPLES);

    logic [DW-1:0]          div_q, div_d;
    logic [NUM_BUTTONS-1:0] sync1_q, sync1_d;
    logic [NUM_BUTTONS-1:0] sync2_q, sync2_d;

    assign sample_tick = (div_q == DIV_LAST);

    always_comb begin
        div_d   = sample_tick ? '0 : div_q + 1'b1;
        sync1_d = button;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_q   <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            div_q   <= div_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BUTTONS; gi++) begin : g_chan
            logic [SW-1:0] stable_q, stable_d;
            logic [HW-1:0] hold_q, hold_d;
            logic          deb_q, deb_d;
            logic          press_q, press_d;
            logic          rel_q, rel_d;
            logic          hold_pulse_q, hold_pulse_d;
            logic          tog_q, tog_d;

            always_comb begin
                stable_d     = stable_q;
                hold_d       = hold_q;
                deb_d        = deb_q;
                press_d      = 1'b0;
                rel_d        = 1'b0;
                hold_pulse_d = 1'b0;
                tog_d        = tog_q;

                // Any tick that agrees with the current level restarts the count,
                // so only an unbroken run of disagreeing ticks flips the level.
                if (sample_tick) begin
                    if (sync2_q[gi] == deb_q) begin
                        stable_d = '0;
                    end else if (stable_q == STABLE_LAST) begin
                        stable_d = '0;
                        deb_d    = sync2_q[gi];
                        press_d  = sync2_q[gi];
                        rel_d    = ~sync2_q[gi];
                    end else begin
                        stable_d = stable_q + 1'b1;
                    end
                end

                // Toggle flips together with the rising debounced level.
                if (press_d && toggle_mode[gi]) begin
                    tog_d = ~tog_q;
                end

                if (!deb_q) begin
                    hold_d = '0;
                end else if (sample_tick && (hold_q != HOLD_MAX)) begin
                    hold_d       = hold_q + 1'b1;
                    hold_pulse_d = (hold_q == HOLD_LAST);
                end
            end

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    stable_q     <= '0;
                    hold_q       <= '0;
                    deb_q        <= 1'b0;
                    press_q      <= 1'b0;
                    rel_q        <= 1'b0;
                    hold_pulse_q <= 1'b0;
                    tog_q        <= 1'b0;
                end else begin
                    stable_q     <= stable_d;
                    hold_q       <= hold_d;
                    deb_q        <= deb_d;
                    press_q      <= press_d;
                    rel_q        <= rel_d;
                    hold_pulse_q <= hold_pulse_d;
                    tog_q        <= tog_d;
                end
            end

            assign debounced[gi]     = deb_q;
            assign press_pulse[gi]   = press_q;
            assign release_pulse[gi] = rel_q;
            assign hold_pulse[gi]    = hold_pulse_q;
            assign button_state[gi]  = toggle_mode[gi] ? tog_q : deb_q;
        end
    endgenerate

endmodule

// File: doc/multi_button_debouncer.md
Name: multi_button_debouncer

Overview:
Parametrised N-channel successor to the single-button debouncer. Raw asynchronous push-button inputs are synchronised and sampled on a shared divided-down tick. Each channel is filtered by a consecutive-stable-sample counter. Each channel provides a debounced level, a per-channel selectable toggle/level output, single-cycle press/release pulses and a long-press (hold) pulse. The block sits between board button pins and the user logic (LED/state controllers).

Parameters:
NUM_BUTTONS, 4, number of independent channels (1..16)
SAMPLE_DIV, 10000, clock cycles per sample tick (>=2); 10 kHz tick at 100 MHz
STABLE_SAMPLES, 8, consecutive ticks the synchronised input must differ from the debounced level before the level flips (>=1)
HOLD_SAMPLES, 5000, ticks the debounced level must stay high before hold_pulse fires (> STABLE_SAMPLES)

Ports:
clock  input  1  system clock; all state on its rising edge
reset  input  1  asynchronous, active-high reset
button  input  NUM_BUTTONS  raw button pins, asynchronous, 1 = pressed
toggle_mode  input  NUM_BUTTONS  per channel: 1 = button_state toggles on each press; 0 = button_state follows debounced level
button_state  output  NUM_BUTTONS  registered per-channel output selected by toggle_mode
debounced  output  NUM_BUTTONS  registered filtered level
press_pulse  output  NUM_BUTTONS  1-cycle pulse on debounced 0->1
release_pulse  output  NUM_BUTTONS  1-cycle pulse on debounced 1->0
hold_pulse  output  NUM_BUTTONS  1-cycle pulse once per press after HOLD_SAMPLES ticks high
sample_tick  output  1  1-cycle strobe, exported for test/other blocks

Behaviour:
- Reset (async assert; deassert takes effect on the next clock edge): all outputs 0; divider, synchroniser flops, stable counters, hold counters and toggle registers all 0.
- Divider: counts 0..SAMPLE_DIV-1 and wraps. sample_tick=1 exactly in the cycle the count equals SAMPLE_DIV-1. First tick occurs SAMPLE_DIV cycles after reset release.
- Synchroniser: two flops per channel. sync[i] lags button[i] by 2 clocks. No logic uses button directly.
- Stable counter (width clog2(STABLE_SAMPLES+1)), evaluated only on sample_tick:
  - sync == debounced: counter <= 0.
  - sync != debounced and counter == STABLE_SAMPLES-1: debounced <= sync, counter <= 0.
  - Otherwise: counter++.
  - Non-tick cycles hold all state. Any single tick agreeing with debounced restarts the count, so bounce shorter than STABLE_SAMPLES ticks never propagates.
- Latency: a clean edge reaches debounced after 2 sync clocks plus STABLE_SAMPLES ticks, i.e. between (STABLE_SAMPLES-1)*SAMPLE_DIV+3 and STABLE_SAMPLES*SAMPLE_DIV+2 clocks, depending on tick phase.
- Pulse timing:
  - press_pulse/release_pulse are registered and high for exactly the one cycle in which the new debounced value first appears.
  - Never both high in the same cycle.
- Toggle: on the press_pulse cycle with toggle_mode[i]=1, the internal toggle register inverts.
  - button_state[i] = toggle_mode[i] ? toggle_reg[i] : debounced[i] (combinational mux of registers, no extra latency).
  - Changing toggle_mode mid-press does not alter toggle_reg.
- Hold counter (width clog2(HOLD_SAMPLES+1)):
  - Cleared while debounced=0.
  - Increments on each tick while debounced=1, saturating at HOLD_SAMPLES.
  - hold_pulse fires for one cycle on the tick where the count reaches HOLD_SAMPLES; no repeat until release and re-press.
- Channels are fully independent. Simultaneous events on several channels are all reported in the same cycle.
- Reset mid-bounce or mid-hold discards all partial counts. No pulse is emitted on reset assertion or release.

Test Plan:
(Bench params: NUM_BUTTONS=2, SAMPLE_DIV=4, STABLE_SAMPLES=3, HOLD_SAMPLES=6.)
1. Reset then idle 40 cycles -> all outputs 0; sample_tick high at cycles 4, 8, 12, … after reset release.
2. button[0] held high from cycle 1 after a tick -> debounced[0] and press_pulse[0] (single cycle) rise on the 3rd tick after sync; button_state[0]=1 with toggle_mode=0.
3. button[0] bounces 1-0-1-0 each 5 cycles for 30 cycles, then stays 0 -> debounced[0], press_pulse[0] never assert.
4. toggle_mode[1]=1; two clean press/release cycles on button[1] -> button_state[1] goes 1 after the first press, 0 after the second; release_pulse[1] fires twice; debounced[1] mirrors the button.
5. button[0] held 40 cycles -> exactly one hold_pulse[0], on the 6th tick after debounced rose; held further -> no repeat; release and re-press -> fires again.
6. Simultaneous press on both channels, then reset asserted mid-count (stable counter=2) -> all outputs 0 immediately; after release, debounce restarts from 0 and needs 3 full ticks.
